idt_cfg_rx: RTL
===============

# idt_cfg_rx

Serial-configuration receiver for the IDT ICS307-style clock-synthesizer programming interface (SCLK/DATA/STROBE). It samples the three lines and shifts in a 24-bit word, MSB first. When the word is latched on STROBE, it decodes the fields and the resulting frequency ratio. It is used as an on-FPGA shadow/monitor of the word sent to the external clock chip, and as the device-side model in simulation benches.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth on all three serial inputs (2 or 3).
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `idt_sclk` in 1: serial clock; data is sampled on its rising edge.
- `idt_data` in 1: serial data.
- `idt_strobe` in 1: latch strobe; its rising edge commits the word.
- `cfg_word` out 24: last valid word, `{C[1:0], TTL, F[1:0], S[2:0], V[8:0], R[6:0]}`.
- `cfg_c` out 2, `cfg_ttl` out 1, `cfg_f` out 2, `cfg_s` out 3: raw fields of `cfg_word`.
- `vdw` out 10: V+8.
- `rdw` out 8: R+2.
- `od` out 4: output divide decoded from S.
- `ratio_num` out 11: 2×vdw.
- `ratio_den` out 11: rdw×od.
- `cfg_valid` out 1: one-cycle pulse; the decoded outputs were just updated.
- `cfg_err` out 1: one-cycle pulse; a strobe arrived with a bit count other than 0 or 24.
- `cfg_loaded` out 1: sticky; at least one valid word has been received since reset.

## Operation
- **Input conditioning.** Each input passes through a `SYNC_STAGES`-flop synchronizer, then one "previous" register for edge detection. All three inputs use identical depth, so their relative alignment is preserved.
- **Shifting.** On a detected `sclk` rise while the synchronized `strobe` is low:
  - `shreg <= {shreg[22:0], data}`.
  - `bitcnt` increments, saturating at 31 (5 bits).
  - `sclk` rises while `strobe` is high are ignored.
- **Strobe rise, by `bitcnt`:**
  - 24: latch `shreg` into `cfg_word`, then run the decode stage.
  - 0: no action. Covers a repeated or held strobe with no new bits.
  - Any other value: pulse `cfg_err`; `cfg_word` and the decoded outputs are unchanged.
  - In every case `bitcnt` clears to 0. `shreg` is not cleared.
- **Simultaneous strobe rise and `sclk` rise:** the strobe wins and the `sclk` bit is discarded.
- **S to `od` mapping:** 000→10, 001→2, 010→8, 011→4, 100→5, 101→7, 110→3, 111→6.
- **Arithmetic.** All arithmetic is unsigned and zero-extended, with no overflow:
  - `vdw` range 8..519.
  - `rdw` range 2..129.
  - `ratio_den` max 1290.
- **States.** Implicit two-state operation:
  - SHIFT: strobe low.
  - HOLD: strobe high; `sclk` is ignored.
  - A falling strobe returns to SHIFT.

## Timing
- Let N be the clock edge at which a pin change is first captured. With `SYNC_STAGES`=2, edge detection is valid in the cycle after N+1.
  - Shift register and counter update at N+2.
  - `cfg_word` updates at N+2 after a strobe rise.
  - Decoded fields, `ratio_*`, `cfg_valid` and `cfg_loaded` update at N+3.
  - `cfg_err` pulses at N+2.
- **Input timing requirements.**
  - `data` must be stable on the clock edge where `sclk` is captured high. Same-domain transmitters that change `data` together with the `sclk` fall meet this.
  - For same-domain drivers, each `sclk`/`strobe` level must last ≥1 clk cycle.
  - For asynchronous drivers, each level must last ≥2 clk cycles.
- **Reset values:**
  - `cfg_word`, `cfg_c`, `cfg_ttl`, `cfg_f`, `cfg_s`, `vdw`, `rdw`, `od`, `ratio_num`, `ratio_den`: 0.
  - `cfg_valid`, `cfg_err`, `cfg_loaded`: 0.
  - `shreg`, `bitcnt`, synchronizers: 0.
- **Reset mid-word:** the partial word is discarded. The next strobe after reset with 24 fresh bits is valid.
- **Throughput:** back-to-back words are accepted with no dead time beyond one strobe low level.

## Test plan
- **Nominal word.** Shift 0x36A7EB MSB first (24 × 1-cycle `sclk` pulses, data held 2 cycles per bit), then raise strobe. Required:
  - `cfg_word`=0x36A7EB; `cfg_c`=00, `cfg_ttl`=1, `cfg_f`=10, `cfg_s`=110.
  - `vdw`=343, `rdw`=109, `od`=3, `ratio_num`=686, `ratio_den`=327.
  - One `cfg_valid` pulse; `cfg_loaded`=1.
- **Repeated strobe.** After the nominal word, lower strobe, raise it again with no `sclk` activity. Required: no `cfg_valid`, no `cfg_err`; outputs hold 0x36A7EB decode.
- **Short word.** Send 23 bits, then strobe. Required: `cfg_err` pulses once; `cfg_word` unchanged. A following full 24-bit word 0x000000 gives `vdw`=8, `rdw`=2, `od`=10, `ratio_den`=20.
- **Overlong word.** Send 40 bits, then strobe. Required: `cfg_err`; `bitcnt` saturates at 31; the next valid word is received correctly.
- **Sclk during strobe high.** Toggle `sclk` 5× while strobe is high, then lower strobe and send a valid word. Required: the ignored edges do not corrupt the word; a single `cfg_valid` pulse.
- **Async reset mid-word.** Assert `rst_n`=0 after 12 bits. Required: all outputs 0 immediately; after release, a full word decodes correctly.

Source files
------------

// File: rtl/idt_cfg_rx.sv
// idt_cfg_rx -- shadow receiver for an ICS307-style SCLK/DATA/STROBE
// programming interface.
//
// The three serial lines are synchronized into clk, bits are shifted MSB
// first on each sclk rise while strobe is low, and a strobe rise commits
// the 24-bit word when exactly 24 bits were collected. One cycle later the
// word is decoded into its raw fields and the synthesizer divide terms.
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   idt_sclk/data/strobe serial configuration lines (any clock domain)
//   cfg_word            last valid word {C,TTL,F,S,V,R}
//   cfg_c/ttl/f/s       raw fields of cfg_word
//   vdw, rdw, od        V+8, R+2, output divide decoded from S
//   ratio_num/den       2*vdw and rdw*od
//   cfg_valid           one-cycle pulse, decoded outputs just updated
//   cfg_err             one-cycle pulse, strobe with bit count not 0/24
//   cfg_loaded          sticky, a valid word was received since reset
module idt_cfg_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        idt_sclk,
  input  logic        idt_data,
  input  logic        idt_strobe,
  output logic [23:0] cfg_word,
  output logic [1:0]  cfg_c,
  output logic        cfg_ttl,
  output logic [1:0]  cfg_f,
  output logic [2:0]  cfg_s,
  output logic [9:0]  vdw,
  output logic [7:0]  rdw,
  output logic [3:0]  od,
  output logic [10:0] ratio_num,
  output logic [10:0] ratio_den,
  output logic        cfg_valid,
  output logic        cfg_err,
  output logic        cfg_loaded
);

  function automatic logic [3:0] od_decode(input logic [2:0] s);
    logic [3:0] r;
    case (s)
      3'd0:    r = 4'd10;
      3'd1:    r = 4'd2;
      3'd2:    r = 4'd8;
      3'd3:    r = 4'd4;
      3'd4:    r = 4'd5;
      3'd5:    r = 4'd7;
      3'd6:    r = 4'd3;
      default: r = 4'd6;
    endcase
    return r;
  endfunction

  logic [SYNC_STAGES-1:0] sclk_sync_q, data_sync_q, strb_sync_q;
  logic                   sclk_prev_q, strb_prev_q;
  logic                   sclk_s, data_s, strb_s;
  logic                   sclk_rise, strb_rise;

  logic [23:0] shreg_q, shreg_d;
  logic [4:0]  bitcnt_q, bitcnt_d;
  logic [23:0] word_q, word_d;
  logic        commit_q, commit_d;
  logic        err_q, err_d;

  logic [1:0]  c_q;
  logic        ttl_q;
  logic [1:0]  f_q;
  logic [2:0]  s_q;
  logic [9:0]  vdw_q;
  logic [7:0]  rdw_q;
  logic [3:0]  od_q;
  logic [10:0] num_q, den_q;
  logic        valid_q, loaded_q;

  logic [9:0]  vdw_d;
  logic [7:0]  rdw_d;
  logic [3:0]  od_d;
  logic [10:0] num_d, den_d;

  // Input synchronizers and edge-detect history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      data_sync_q <= '0;
      strb_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      strb_prev_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], idt_sclk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], idt_data};
      strb_sync_q <= {strb_sync_q[SYNC_STAGES-2:0], idt_strobe};
      sclk_prev_q <= sclk_s;
      strb_prev_q <= strb_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign data_s    = data_sync_q[SYNC_STAGES-1];
  assign strb_s    = strb_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign strb_rise = strb_s & ~strb_prev_q;

  // Shift / commit control. A strobe rise takes priority over a coincident
  // sclk rise, and sclk is ignored for as long as strobe stays high.
  always_comb begin
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    word_d   = word_q;
    commit_d = 1'b0;
    err_d    = 1'b0;
    if (strb_rise) begin
      bitcnt_d = 5'd0;
      if (bitcnt_q == 5'd24) begin
        word_d   = shreg_q;
        commit_d = 1'b1;
      end else if (bitcnt_q != 5'd0) begin
        err_d = 1'b1;
      end
    end else if (sclk_rise && !strb_s) begin
      shreg_d  = {shreg_q[22:0], data_s};
      bitcnt_d = (bitcnt_q == 5'd31) ? 5'd31 : bitcnt_q + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q  <= '0;
      bitcnt_q <= '0;
      word_q   <= '0;
      commit_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      word_q   <= word_d;
      commit_q <= commit_d;
      err_q    <= err_d;
    end
  end

  // Decode stage: fields and divide terms from the committed word
  assign vdw_d = {1'b0, word_q[15:7]} + 10'd8;
  assign rdw_d = {1'b0, word_q[6:0]} + 8'd2;
  assign od_d  = od_decode(word_q[18:16]);
  assign num_d = {vdw_d, 1'b0};
  assign den_d = {3'b0, rdw_d} * {7'b0, od_d};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q      <= '0;
      ttl_q    <= 1'b0;
      f_q      <= '0;
      s_q      <= '0;
      vdw_q    <= '0;
      rdw_q    <= '0;
      od_q     <= '0;
      num_q    <= '0;
      den_q    <= '0;
      valid_q  <= 1'b0;
      loaded_q <= 1'b0;
    end else begin
      valid_q <= commit_q;
      if (commit_q) begin
        c_q      <= word_q[23:22];
        ttl_q    <= word_q[21];
        f_q      <= word_q[20:19];
        s_q      <= word_q[18:16];
        vdw_q    <= vdw_d;
        rdw_q    <= rdw_d;
        od_q     <= od_d;
        num_q    <= num_d;
        den_q    <= den_d;
        loaded_q <= 1'b1;
      end
    end
  end

  assign cfg_word   = word_q;
  assign cfg_c      = c_q;
  assign cfg_ttl    = ttl_q;
  assign cfg_f      = f_q;
  assign cfg_s      = s_q;
  assign vdw        = vdw_q;
  assign rdw        = rdw_q;
  assign od         = od_q;
  assign ratio_num  = num_q;
  assign ratio_den  = den_q;
  assign cfg_valid  = valid_q;
  assign cfg_err    = err_q;
  assign cfg_loaded = loaded_q;

endmodule
